// File: rtl/manual_drive_fsm_pkg.sv
// manual_drive_fsm_pkg: state encodings, mode constant, answer bit indices and default thresholds
package manual_drive_fsm_pkg;
    typedef enum logic [3:0] {
        NOT_STARTING = 4'b0001,
        STARTING     = 4'b0010,
        MOVING       = 4'b0100,
        POWER_OFF    = 4'b1000
    } state_t;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam int ANS_LEFT  = 3;
    localparam int ANS_RIGHT = 2;
    localparam int ANS_BACK  = 1;
    localparam int ANS_FWD   = 0;
    localparam int DEF_PWR_ON_TICKS = 2;
    localparam int DEF_IDLE_TICKS   = 20;
endpackage

// File: rtl/manual_drive_fsm_button_hold_detect.sv
// button_hold_detect: pulses while level has been high for N consecutive enabled ticks
module button_hold_detect #(
    parameter int N = 2
) (
    input  logic clk_2hz,
    input  logic rst,
    input  logic en,
    input  logic level,
    output logic pulse
);
    localparam int W = $clog2(N + 1);
    logic [W-1:0] cnt;
    assign pulse = en && level && cnt == W'(N - 1);
    // count consecutive high ticks, saturate once the threshold is reached, clear on release
    always_ff @(posedge clk_2hz or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (en) cnt <= !level ? '0 : pulse ? cnt : cnt + 1'b1;
    end
endmodule

// File: rtl/manual_drive_fsm.sv
// manual_drive_fsm: manual-driving car controller with power, gear and idle supervision
module manual_drive_fsm
    import manual_drive_fsm_pkg::*;
#(
    parameter int PWR_ON_TICKS = DEF_PWR_ON_TICKS,
    parameter int IDLE_TICKS   = DEF_IDLE_TICKS
) (
    input  logic        clk_2hz,
    input  logic        rst,
    input  logic [1:0]  module_choose,
    input  logic        power_on_btn,
    input  logic        power_off_btn,
    input  logic        throttle,
    input  logic        brake,
    input  logic        clutch,
    input  logic        reverse_sw,
    input  logic        left_sw,
    input  logic        right_sw,
    output logic        power_now,
    output logic [3:0]  state,
    output logic [3:0]  answer,
    output logic [15:0] mileage
);
    localparam int IW = $clog2(IDLE_TICKS + 1);
    state_t          cur, nxt;
    logic            latch, latch_nxt, manual, gear_stall, idle, pwr_on, driving;
    logic [IW-1:0]   idle_cnt, idle_inc;
    logic [3:0]      ans_nxt;
    assign state = cur;
    button_hold_detect #(.N(PWR_ON_TICKS)) u_hold (
        .clk_2hz(clk_2hz),
        .rst    (rst),
        .en     (manual),
        .level  (power_on_btn && cur == POWER_OFF),
        .pulse  (pwr_on)
    );
    // next state, gear latch, idle count and answer derived from the current tick's controls
    always_comb begin
        manual     = module_choose == MODE_MANUAL;
        driving    = cur == STARTING || cur == MOVING;
        gear_stall = driving && !clutch && reverse_sw != latch;
        idle       = !(throttle || brake || clutch || left_sw || right_sw);
        idle_inc   = (cur == NOT_STARTING && idle) ? idle_cnt + 1'b1 : '0;
        latch_nxt  = gear_stall ? latch : reverse_sw;
        nxt        = cur;
        if (power_off_btn || gear_stall) nxt = POWER_OFF;
        else case (cur)
            POWER_OFF:    nxt = pwr_on ? NOT_STARTING : POWER_OFF;
            NOT_STARTING: nxt = (throttle && clutch && !brake) ? STARTING :
                                (throttle && !clutch) ? POWER_OFF :
                                (idle_inc == IW'(IDLE_TICKS)) ? POWER_OFF : NOT_STARTING;
            STARTING:     nxt = brake ? NOT_STARTING : (throttle && !clutch) ? MOVING : STARTING;
            MOVING:       nxt = brake ? NOT_STARTING : (clutch || !throttle) ? STARTING : MOVING;
            default:      nxt = POWER_OFF;
        endcase
        ans_nxt            = '0;
        ans_nxt[ANS_LEFT]  = (nxt == STARTING || nxt == MOVING) && left_sw && !right_sw;
        ans_nxt[ANS_RIGHT] = (nxt == STARTING || nxt == MOVING) && right_sw && !left_sw;
        ans_nxt[ANS_BACK]  = nxt == MOVING && latch_nxt;
        ans_nxt[ANS_FWD]   = nxt == MOVING && !latch_nxt;
    end
    // register everything; outside manual mode only answer changes (forced to zero)
    always_ff @(posedge clk_2hz or negedge rst) begin
        if (!rst) begin
            cur       <= POWER_OFF;
            latch     <= 1'b0;
            idle_cnt  <= '0;
            mileage   <= '0;
            power_now <= 1'b0;
            answer    <= '0;
        end else if (manual) begin
            cur       <= nxt;
            latch     <= latch_nxt;
            idle_cnt  <= nxt == NOT_STARTING ? idle_inc : '0;
            mileage   <= nxt == POWER_OFF ? '0 : cur == MOVING ? mileage + 16'd1 : mileage;
            power_now <= nxt != POWER_OFF;
            answer    <= ans_nxt;
        end else begin
            answer    <= '0;
        end
    end
endmodule

// File: tb/tb_manual_drive_fsm.sv
// tb_manual_drive_fsm: directed stimulus, spec-level reference model and per-cycle output compare
module tb_manual_drive_fsm;
    localparam int PWR  = 2;
    localparam int IDLE = 20;
    logic        clk_2hz = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  module_choose = 2'b01;
    logic        power_on_btn = 0, power_off_btn = 0, throttle = 0, brake = 0, clutch = 0;
    logic        reverse_sw = 0, left_sw = 0, right_sw = 0;
    logic        power_now;
    logic [3:0]  state, answer;
    logic [15:0] mileage;
    int          errors = 0, checks = 0;
    logic [3:0]  m_st = 4'b1000;
    logic [3:0]  m_ans = 4'b0000;
    logic [15:0] m_mile = 16'd0;
    logic        m_latch = 1'b0;
    int          m_hold = 0, m_idle = 0;

    manual_drive_fsm #(.PWR_ON_TICKS(PWR), .IDLE_TICKS(IDLE)) dut (
        .clk_2hz(clk_2hz), .rst(rst), .module_choose(module_choose),
        .power_on_btn(power_on_btn), .power_off_btn(power_off_btn),
        .throttle(throttle), .brake(brake), .clutch(clutch), .reverse_sw(reverse_sw),
        .left_sw(left_sw), .right_sw(right_sw),
        .power_now(power_now), .state(state), .answer(answer), .mileage(mileage)
    );

    always #5 clk_2hz = ~clk_2hz;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_2hz);
    endtask

    // reference model: states are their one-hot output codes, rules applied straight from the requirements
    always @(posedge clk_2hz or negedge rst) begin : model
        logic [3:0] ns;
        logic bad_shift, quiet, drv;
        if (!rst) begin
            m_st = 4'b1000; m_ans = 0; m_mile = 0; m_latch = 0; m_hold = 0; m_idle = 0;
        end else if (module_choose != 2'b01) begin
            m_ans = 0;
        end else begin
            bad_shift = (m_st == 4'b0010 || m_st == 4'b0100) && !clutch && reverse_sw != m_latch;
            quiet = !(throttle || brake || clutch || left_sw || right_sw);
            m_hold = (m_st == 4'b1000 && power_on_btn) ? m_hold + 1 : 0;
            m_idle = (m_st == 4'b0001 && quiet) ? m_idle + 1 : 0;
            if (power_off_btn || bad_shift) ns = 4'b1000;
            else if (m_st == 4'b1000) ns = (m_hold >= PWR) ? 4'b0001 : 4'b1000;
            else if (m_st == 4'b0001)
                ns = (throttle && clutch && !brake) ? 4'b0010 :
                     (throttle && !clutch) ? 4'b1000 : (m_idle >= IDLE) ? 4'b1000 : 4'b0001;
            else if (brake) ns = 4'b0001;
            else if (m_st == 4'b0010) ns = (throttle && !clutch) ? 4'b0100 : 4'b0010;
            else ns = (clutch || !throttle) ? 4'b0010 : 4'b0100;
            if (m_st == 4'b0100) m_mile = m_mile + 16'd1;
            if (ns == 4'b1000) m_mile = 0;
            if (!bad_shift) m_latch = reverse_sw;
            drv = ns == 4'b0010 || ns == 4'b0100;
            m_ans = {drv && left_sw && !right_sw, drv && right_sw && !left_sw,
                     ns == 4'b0100 && m_latch, ns == 4'b0100 && !m_latch};
            m_st = ns;
        end
    end

    // compare every output against the model away from the active edge
    always @(negedge clk_2hz) begin
        if (rst) begin
            chk("model_state", {12'd0, state}, {12'd0, m_st});
            chk("model_power", {15'd0, power_now}, {15'd0, m_st != 4'b1000});
            chk("model_answer", {12'd0, answer}, {12'd0, m_ans});
            chk("model_mileage", mileage, m_mile);
        end
    end

    task automatic power_up();
        power_on_btn = 1; step(PWR); power_on_btn = 0;
    endtask

    task automatic drive_off();
        throttle = 1; clutch = 1; step(); clutch = 0; step();
    endtask

    initial begin
        #2 rst = 0;
        #1 chk("rst_state", {12'd0, state}, 16'h0008);
        chk("rst_power", {15'd0, power_now}, 16'h0000);
        chk("rst_mileage", mileage, 16'h0000);
        chk("rst_answer", {12'd0, answer}, 16'h0000);
        step(); #2 rst = 1; step();
        power_on_btn = 1; step(); power_on_btn = 0; step();
        chk("short_hold", {12'd0, state}, 16'h0008);
        power_up();
        chk("hold_on_state", {12'd0, state}, 16'h0001);
        chk("hold_on_power", {15'd0, power_now}, 16'h0001);
        throttle = 1; clutch = 1; step();
        chk("to_starting", {12'd0, state}, 16'h0002);
        clutch = 0; step();
        chk("to_moving", {12'd0, state}, 16'h0004);
        chk("fwd_answer", {12'd0, answer}, 16'h0001);
        for (int i = 1; i <= 3; i++) begin
            step(); chk("mileage_count", mileage, 16'(i));
        end
        left_sw = 1; step();
        chk("left_answer", {12'd0, answer}, 16'h0009);
        right_sw = 1; step();
        chk("both_sw_answer", {12'd0, answer}, 16'h0001);
        left_sw = 0; right_sw = 0;
        chk("mileage_5", mileage, 16'd5);
        brake = 1; step();
        chk("brake_state", {12'd0, state}, 16'h0001);
        chk("brake_answer", {12'd0, answer}, 16'h0000);
        chk("brake_mileage", mileage, 16'd6);
        brake = 0; drive_off(); step();
        chk("mileage_7", mileage, 16'd7);
        reverse_sw = 1; step();
        chk("stall_state", {12'd0, state}, 16'h0008);
        chk("stall_power", {15'd0, power_now}, 16'h0000);
        chk("stall_mileage", mileage, 16'd0);
        throttle = 0; reverse_sw = 0;
        power_up(); drive_off();
        clutch = 1; reverse_sw = 1; step();
        chk("clutch_shift", {12'd0, state}, 16'h0002);
        clutch = 0; step();
        chk("back_answer", {12'd0, answer}, 16'h0002);
        brake = 1; step(); brake = 0; throttle = 0;
        step(19);
        chk("idle_19", {12'd0, state}, 16'h0001);
        left_sw = 1; step(); left_sw = 0;
        step(19);
        chk("idle_restart", {12'd0, state}, 16'h0001);
        step();
        chk("idle_off", {12'd0, state}, 16'h0008);
        reverse_sw = 0; power_up(); drive_off(); step(2);
        chk("pre_freeze_mileage", mileage, 16'd2);
        module_choose = 2'b10; step(2);
        chk("freeze_state", {12'd0, state}, 16'h0004);
        chk("freeze_answer", {12'd0, answer}, 16'h0000);
        chk("freeze_mileage", mileage, 16'd2);
        module_choose = 2'b01; step();
        chk("resume_mileage", mileage, 16'd3);
        #2 rst = 0;
        #1 chk("async_rst_state", {12'd0, state}, 16'h0008);
        chk("async_rst_mileage", mileage, 16'd0);
        throttle = 0; step(); #1 rst = 1;
        power_on_btn = 1; step();
        chk("rst_needs_hold", {12'd0, state}, 16'h0008);
        step(); power_on_btn = 0;
        chk("rst_rehold", {12'd0, state}, 16'h0001);
        power_off_btn = 1; step(); power_off_btn = 0;
        chk("power_off_btn", {12'd0, state}, 16'h0008);
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
